rgb_palette_lut: RTL and testbench

//  Programmable colour-palette lookup: maps a colour index to a packed RGB word.

---
 rtl/rgb_pkg.sv | 23 ++
 rtl/rgb_palette_lut_if.sv | 14 +
 rtl/palette_ram.sv | 19 +
 rtl/rgb_palette_lut.sv | 73 +++++++
 tb/tb_rgb_palette_lut.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared FSM state type, default colour indices and the default palette rule
package rgb_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int BLACK   = 0;
  localparam int BLUE    = 1;
  localparam int GREEN   = 2;
  localparam int CYAN    = 3;
  localparam int RED     = 4;
  localparam int MAGENTA = 5;
  localparam int YELLOW  = 6;
  localparam int WHITE   = 7;
  // Result is left-padded to 96 bits; callers truncate to 3*ch_w (ch_w <= 32).
  function automatic logic [95:0] default_rgb(input int idx, input int ch_w);
    logic [95:0] ones;
    logic r, g, b;
    ones = (96'd1 << ch_w) - 96'd1;
    r = idx inside {RED, MAGENTA, YELLOW, WHITE};
    g = idx inside {GREEN, CYAN, YELLOW, WHITE};
    b = idx inside {BLUE, CYAN, MAGENTA, WHITE};
    if (idx < BLACK || idx > WHITE) return '0;
    return (r ? ones << (2 * ch_w) : '0) | (g ? ones << ch_w : '0) | (b ? ones : '0);
  endfunction
endpackage

// File: rtl/rgb_palette_lut_if.sv
// rgb_palette_lut_if: read stream, write port and status of the palette lookup
interface rgb_palette_lut_if #(parameter int ADDR_W = 3, parameter int CH_W = 8);
  logic in_valid, in_ready, out_valid, out_ready, wr_en, busy, wr_err;
  logic [ADDR_W-1:0] in_index, wr_addr;
  logic [3*CH_W-1:0] out_rgb, wr_data;
  modport master (
    output in_valid, in_index, out_ready, wr_en, wr_addr, wr_data,
    input  in_ready, out_valid, out_rgb, busy, wr_err
  );
  modport slave (
    input  in_valid, in_index, out_ready, wr_en, wr_addr, wr_data,
    output in_ready, out_valid, out_rgb, busy, wr_err
  );
endinterface

// File: rtl/palette_ram.sv
// palette_ram: simple dual-port RAM, one write port, read-first synchronous read with enable
module palette_ram #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rgb_palette_lut.sv
// rgb_palette_lut: self-initialising, runtime-writable palette with a 2-stage valid/ready read path
module rgb_palette_lut
  import rgb_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CH_W   = 8
) (
  input logic clk,
  input logic rst,
  rgb_palette_lut_if.slave bus_io
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int DATA_W = 3 * CH_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d, ram_waddr;
  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, wr_err_q, wr_err_d;
  logic [DATA_W-1:0] out_rgb_q, out_rgb_d, ram_rdata, ram_wdata;
  logic in_run, adv, accept, ram_we;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end
  always_comb begin
    state_d    = (state_q == INIT && init_ptr_q == LAST) ? RUN : state_q;
    init_ptr_d = (state_q == INIT && init_ptr_q != LAST) ? init_ptr_q + 1'b1 : init_ptr_q;
  end
  // adv=0 freezes stage 1, the RAM read enable and the output register together.
  always_comb begin
    in_run      = state_q == RUN;
    adv         = !out_valid_q || bus_io.out_ready;
    accept      = bus_io.in_valid && in_run && adv;
    ram_we      = in_run ? bus_io.wr_en : 1'b1;
    ram_waddr   = in_run ? bus_io.wr_addr : init_ptr_q;
    ram_wdata   = in_run ? bus_io.wr_data : DATA_W'(default_rgb(int'(init_ptr_q), CH_W));
    s1_valid_d  = adv ? accept : s1_valid_q;
    out_valid_d = adv ? s1_valid_q : out_valid_q;
    out_rgb_d   = (adv && s1_valid_q) ? ram_rdata : out_rgb_q;
    wr_err_d    = wr_err_q || (!in_run && bus_io.wr_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_rgb_q   <= out_rgb_d;
      wr_err_q    <= wr_err_d;
    end
  end
  palette_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (accept),
    .raddr(bus_io.in_index),
    .rdata(ram_rdata)
  );
  assign bus_io.in_ready  = in_run && adv;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_rgb   = out_rgb_q;
  assign bus_io.busy      = !in_run;
  assign bus_io.wr_err    = wr_err_q;
endmodule

// File: tb/tb_rgb_palette_lut.sv
// tb_rgb_palette_lut: directed vectors plus a per-cycle scoreboard model of the default-size palette
module tb_rgb_palette_lut;
  logic clk = 1'b0, rst = 1'b1, rst1 = 1'b1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rgb_palette_lut_if #(.ADDR_W(3), .CH_W(8)) b0 ();
  rgb_palette_lut_if #(.ADDR_W(4), .CH_W(5)) b1 ();
  rgb_palette_lut #(.ADDR_W(3), .CH_W(8)) dut0 (.clk(clk), .rst(rst), .bus_io(b0));
  rgb_palette_lut #(.ADDR_W(4), .CH_W(5)) dut1 (.clk(clk), .rst(rst1), .bus_io(b1));
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [23:0] dflt(input int i);
    return {(i >= 4) ? 8'hFF : 8'h00, (i % 4 >= 2) ? 8'hFF : 8'h00, (i % 2 == 1) ? 8'hFF : 8'h00};
  endfunction
  // Scoreboard: palette contents, pending results and sticky error, updated at each handshake.
  logic [23:0] mm [8];
  logic [23:0] q [$];
  int since = 0;
  bit err_exp = 0, pstall = 0, busy_e;
  logic [23:0] prgb;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      since = 0;
      err_exp = 0;
      pstall = 0;
      for (int i = 0; i < 8; i++) mm[i] = dflt(i);
    end else begin
      busy_e = since < 8;
      chk("busy", b0.busy, busy_e);
      chk("in_ready", b0.in_ready, !busy_e && (!b0.out_valid || b0.out_ready));
      chk("wr_err", b0.wr_err, err_exp);
      if (pstall) begin
        chk("stall_valid", b0.out_valid, 1);
        chk("stall_rgb", b0.out_rgb, prgb);
      end
      if (b0.out_valid) begin
        chk("pending", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("rgb", b0.out_rgb, q[0]);
      end
      if (b0.out_valid && b0.out_ready && q.size() != 0) void'(q.pop_front());
      if (b0.in_valid && b0.in_ready) q.push_back(mm[b0.in_index]);
      if (b0.wr_en && !busy_e) mm[b0.wr_addr] = b0.wr_data;
      if (b0.wr_en && busy_e) err_exp = 1;
      pstall = b0.out_valid && !b0.out_ready;
      prgb = b0.out_rgb;
      since++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  logic [23:0] exp8 [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                            24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
  logic [14:0] exp1 [3] = '{15'h7FFF, 15'h0000, 15'h7C00};
  logic [3:0] idx1 [3] = '{4'd7, 4'd12, 4'd4};
  int n;
  initial begin
    {b0.in_valid, b0.in_index, b0.out_ready, b0.wr_en, b0.wr_addr, b0.wr_data} = '0;
    {b1.in_valid, b1.in_index, b1.out_ready, b1.wr_en, b1.wr_addr, b1.wr_data} = '0;
    repeat (2) step();
    rst = 0;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out_rgb", b0.out_rgb, 0);
    chk("rst_wr_err", b0.wr_err, 0);
    n = 0;
    while (b0.busy && n < 20) begin
      chk("init_in_ready", b0.in_ready, 0);
      b0.wr_en = (n == 3);
      b0.wr_addr = 3'd5;
      b0.wr_data = 24'h123123;
      n++;
      step();
    end
    b0.wr_en = 0;
    chk("init_len", n, 8);
    chk("init_wr_err", b0.wr_err, 1);
    b0.out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      b0.in_valid = k < 8;
      b0.in_index = 3'(k);
      step();
      if (k == 0 || k == 9) chk("seq_valid_lo", b0.out_valid, 0);
      else begin
        chk("seq_valid", b0.out_valid, 1);
        chk("seq_rgb", b0.out_rgb, exp8[k-1]);
      end
    end
    b0.in_valid = 1;
    b0.in_index = 3'd4;
    step();
    b0.in_index = 3'd5;
    step();
    b0.out_ready = 0;
    b0.in_index = 3'd6;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rgb", b0.out_rgb, 24'hFF0000);
      chk("bp_valid", b0.out_valid, 1);
      chk("bp_in_ready", b0.in_ready, 0);
      step();
    end
    b0.out_ready = 1;
    #1;
    chk("bp_rel0", b0.out_rgb, 24'hFF0000);
    chk("bp_rel_ready", b0.in_ready, 1);
    step();
    chk("bp_rel1", b0.out_rgb, 24'hFF00FF);
    b0.in_valid = 0;
    step();
    chk("bp_rel2", b0.out_rgb, 24'hFFFF00);
    step();
    chk("bp_drain", b0.out_valid, 0);
    b0.wr_en = 1;
    b0.wr_addr = 3'd3;
    b0.wr_data = 24'h123456;
    step();
    b0.wr_en = 0;
    b0.in_valid = 1;
    b0.in_index = 3'd3;
    step();
    b0.in_valid = 0;
    step();
    chk("wr_rd", b0.out_rgb, 24'h123456);
    b0.wr_en = 1;
    b0.wr_addr = 3'd2;
    b0.wr_data = 24'hABCDEF;
    b0.in_valid = 1;
    b0.in_index = 3'd2;
    step();
    b0.wr_en = 0;
    step();
    b0.in_valid = 0;
    chk("rd_first_old", b0.out_rgb, 24'h00FF00);
    step();
    chk("rd_first_new", b0.out_rgb, 24'hABCDEF);
    b0.in_valid = 1;
    b0.in_index = 3'd1;
    step();
    b0.in_index = 3'd2;
    step();
    b0.in_valid = 0;
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_valid", b0.out_valid, 0);
    chk("mid_rst_busy", b0.busy, 1);
    chk("mid_rst_wr_err", b0.wr_err, 0);
    n = 0;
    while (b0.busy && n < 20) begin
      n++;
      step();
    end
    chk("reinit_len", n, 8);
    b0.in_valid = 1;
    b0.in_index = 3'd3;
    step();
    b0.in_valid = 0;
    step();
    chk("reinit_rd3", b0.out_rgb, 24'h00FFFF);
    b1.out_ready = 1;
    rst1 = 0;
    n = 0;
    while (b1.busy && n < 40) begin
      n++;
      step();
    end
    chk("p_init_len", n, 16);
    for (int k = 0; k < 5; k++) begin
      b1.in_valid = k < 3;
      b1.in_index = idx1[k % 3];
      step();
      if (k >= 1 && k <= 3) begin
        chk("p_valid", b1.out_valid, 1);
        chk("p_rgb", b1.out_rgb, exp1[k-1]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
